difftest_step_scheduler: RTL and testbench

DIFFTEST_STEP_SCHEDULER -- requirements
Module: difftest_step_scheduler

---
 rtl/difftest_step_scheduler_pkg.sv | 17 +
 rtl/difftest_rr_picker.sv | 28 ++
 rtl/difftest_step_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_difftest_step_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_step_scheduler_pkg.sv
// Shared definitions for the difftest step scheduler: bridge result codes
// and the issue FSM state encoding.
package difftest_step_scheduler_pkg;

    localparam logic [7:0] SIMV_GOODTRAP = 8'd1;
    localparam logic [7:0] SIMV_EXCEED   = 8'd2;
    localparam logic [7:0] SIMV_FAIL     = 8'd3;
    localparam logic [7:0] SIMV_WARMUP   = 8'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_HALT      = 2'd3
    } sched_state_t;

endpackage

// File: rtl/difftest_rr_picker.sv
// Combinational round-robin picker: first requesting index at or after the
// pointer, wrapping around the request vector.
module difftest_rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    int w_idx;

    always_comb begin
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        w_idx         = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!o_grant_valid && i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = IDX_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/difftest_step_scheduler.sv
// Accumulates per-core commit steps and issues them one core at a time to a
// single DPI step bridge, with an idle watchdog and a halt on FAIL results.
module difftest_step_scheduler
    import difftest_step_scheduler_pkg::*;
#(
    parameter  int NUM_CORES = 2,
    parameter  int STEP_W    = 8,
    parameter  int ACC_W     = 16,
    localparam int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_CORES*STEP_W-1:0] core_step,
    input  logic [63:0]                 stuck_limit,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [IDX_W-1:0]            issue_core,
    output logic [STEP_W-1:0]           issue_nstep,
    input  logic                        resp_valid,
    input  logic [7:0]                  resp_result,
    output logic [7:0]                  result,
    output logic [IDX_W-1:0]            result_core,
    output logic                        halted,
    output logic                        stuck,
    output logic [IDX_W-1:0]            stuck_core,
    output logic                        overflow
);

    localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] STEP_MAX = ACC_W'({STEP_W{1'b1}});

    sched_state_t        r_state;
    logic [ACC_W-1:0]    r_acc      [NUM_CORES];
    logic [63:0]         r_idle_cnt [NUM_CORES];
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [IDX_W-1:0]    r_issue_core;
    logic [STEP_W-1:0]   r_issue_nstep;
    logic [7:0]          r_result;
    logic [IDX_W-1:0]    r_result_core;
    logic                r_stuck;
    logic [IDX_W-1:0]    r_stuck_core;
    logic                r_overflow;

    logic [NUM_CORES-1:0] w_req;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_do_grant;
    logic [ACC_W-1:0]     w_grant_acc;
    logic [ACC_W-1:0]     w_grant_amt;
    logic [IDX_W-1:0]     w_rr_next;
    logic [ACC_W:0]       w_acc_sum  [NUM_CORES];
    logic [NUM_CORES-1:0] w_stuck_hit;
    logic [IDX_W-1:0]     w_stuck_idx;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_req[i] = (r_acc[i] != '0);
        end
    end

    difftest_rr_picker #(
        .N     (NUM_CORES),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req         (w_req),
        .i_ptr         (r_rr_ptr),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    // Grants are capped at the bridge step width; any residue stays pending.
    assign w_do_grant  = (r_state == ST_IDLE) && w_grant_valid;
    assign w_grant_acc = r_acc[w_grant_idx];
    assign w_grant_amt = (w_grant_acc > STEP_MAX) ? STEP_MAX : w_grant_acc;
    assign w_rr_next   = (int'(w_grant_idx) == NUM_CORES - 1) ? '0 : w_grant_idx + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            w_acc_sum[i] = {1'b0, r_acc[i]} + (ACC_W+1)'(core_step[i*STEP_W +: STEP_W]);
            if (w_do_grant && (int'(w_grant_idx) == i)) begin
                w_acc_sum[i] = w_acc_sum[i] - {1'b0, w_grant_amt};
            end
        end
    end

    // The grant never exceeds acc, so the extra sum bit only flags true overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_acc[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (w_acc_sum[i][ACC_W]) begin
                    r_acc[i]   <= ACC_MAX;
                    r_overflow <= 1'b1;
                end else begin
                    r_acc[i] <= w_acc_sum[i][ACC_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_stuck_hit = '0;
        w_stuck_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            w_stuck_hit[i] = (stuck_limit != 64'd0) && (r_idle_cnt[i] >= stuck_limit);
            if (w_stuck_hit[i]) begin
                w_stuck_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                r_idle_cnt[i] <= '0;
            end
            r_stuck      <= 1'b0;
            r_stuck_core <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (core_step[i*STEP_W +: STEP_W] != '0) begin
                    r_idle_cnt[i] <= '0;
                end else if (r_idle_cnt[i] != {64{1'b1}}) begin
                    r_idle_cnt[i] <= r_idle_cnt[i] + 64'd1;
                end
            end
            if (!r_stuck && (w_stuck_hit != '0)) begin
                r_stuck      <= 1'b1;
                r_stuck_core <= w_stuck_idx;
            end
        end
    end

    // Result is a one-cycle pulse; responses outside WAIT_RESP are dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_issue_core  <= '0;
            r_issue_nstep <= '0;
            r_result      <= '0;
            r_result_core <= '0;
        end else begin
            r_result <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_issue_core  <= w_grant_idx;
                        r_issue_nstep <= w_grant_amt[STEP_W-1:0];
                        r_rr_ptr      <= w_rr_next;
                        r_state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue_ready) begin
                        r_state <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (resp_valid) begin
                        r_result      <= resp_result;
                        r_result_core <= r_issue_core;
                        r_state       <= (resp_result == SIMV_FAIL) ? ST_HALT : ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign issue_valid = (r_state == ST_ISSUE);
    assign halted      = (r_state == ST_HALT);
    assign issue_core  = r_issue_core;
    assign issue_nstep = r_issue_nstep;
    assign result      = r_result;
    assign result_core = r_result_core;
    assign stuck       = r_stuck;
    assign stuck_core  = r_stuck_core;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_difftest_step_scheduler.sv
// Directed, table-driven bench for difftest_step_scheduler with hand-written
// sequences for back-pressure, halt, watchdog, overflow and reset corners.
`timescale 1ns/1ps
module tb_difftest_step_scheduler;
    import difftest_step_scheduler_pkg::*;

    logic        clock;
    logic        reset;
    logic [15:0] core_step;
    logic [63:0] stuck_limit;
    logic        issue_valid;
    logic        issue_ready;
    logic [0:0]  issue_core;
    logic [7:0]  issue_nstep;
    logic        resp_valid;
    logic [7:0]  resp_result;
    logic [7:0]  result;
    logic [0:0]  result_core;
    logic        halted;
    logic        stuck;
    logic [0:0]  stuck_core;
    logic        overflow;

    int checkCount;
    int failCount;

    typedef struct {
        logic [7:0] step0;
        logic [7:0] step1;
        logic       ready;
        logic       rValid;
        logic [7:0] rResult;
        logic       expValid;
        logic [0:0] expCore;
        logic [7:0] expNstep;
        logic [7:0] expResult;
        logic       expHalted;
    } vec_t;

    vec_t vecs [12];

    difftest_step_scheduler #(
        .NUM_CORES (2),
        .STEP_W    (8),
        .ACC_W     (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .core_step   (core_step),
        .stuck_limit (stuck_limit),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_core  (issue_core),
        .issue_nstep (issue_nstep),
        .resp_valid  (resp_valid),
        .resp_result (resp_result),
        .result      (result),
        .result_core (result_core),
        .halted      (halted),
        .stuck       (stuck),
        .stuck_core  (stuck_core),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL globalTimeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    function automatic vec_t mkVec(input logic [7:0] s0, input logic [7:0] s1, input logic rdy,
                                   input logic rv, input logic [7:0] rr, input logic ev,
                                   input logic [0:0] ec, input logic [7:0] en,
                                   input logic [7:0] eres, input logic eh);
        vec_t v;
        v.step0 = s0; v.step1 = s1; v.ready = rdy; v.rValid = rv; v.rResult = rr;
        v.expValid = ev; v.expCore = ec; v.expNstep = en; v.expResult = eres; v.expHalted = eh;
        return v;
    endfunction

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] s0, input logic [7:0] s1, input logic rdy,
                                 input logic rv, input logic [7:0] rr);
        core_step   = {s1, s0};
        issue_ready = rdy;
        resp_valid  = rv;
        resp_result = rr;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
        reset = 1'b1;
        nextCycle();
        nextCycle();
        reset = 1'b0;
    endtask

    // Waits for an issue, accepts it, then answers with the given code.
    task automatic serveOne(input logic [7:0] code, output logic [0:0] gotCore,
                            output logic [7:0] gotNstep, output logic seen);
        seen     = 1'b0;
        gotCore  = '0;
        gotNstep = '0;
        for (int k = 0; k < 50 && !seen; k++) begin
            if (issue_valid) begin
                seen     = 1'b1;
                gotCore  = issue_core;
                gotNstep = issue_nstep;
            end else begin
                nextCycle();
            end
        end
        if (seen) begin
            issue_ready = 1'b1;
            nextCycle();
            resp_valid  = 1'b1;
            resp_result = code;
            nextCycle();
            resp_valid  = 1'b0;
        end
    endtask

    initial begin
        logic [0:0] gCore;
        logic [7:0] gNstep;
        logic       gSeen;
        logic       sawValid;

        checkCount  = 0;
        failCount   = 0;
        reset       = 1'b1;
        stuck_limit = 64'd0;
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);

        // Single grant on core 0, GOODTRAP response, stray FAIL ignored in IDLE.
        for (int k = 0; k < 5; k++) vecs[k] = mkVec(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        vecs[5]  = mkVec(8'd3, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        vecs[6]  = mkVec(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        vecs[7]  = mkVec(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 8'd0, 1'b0);
        vecs[8]  = mkVec(8'd0, 8'd0, 1'b1, 1'b1, SIMV_GOODTRAP, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        vecs[9]  = mkVec(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd1, 1'b0);
        vecs[10] = mkVec(8'd0, 8'd0, 1'b1, 1'b1, SIMV_FAIL, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        vecs[11] = mkVec(8'd0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);

        resetDut();
        checkOutput("rstIssueValid", 64'(issue_valid), 64'd0);
        checkOutput("rstIssueCore", 64'(issue_core), 64'd0);
        checkOutput("rstIssueNstep", 64'(issue_nstep), 64'd0);
        checkOutput("rstResult", 64'(result), 64'd0);
        checkOutput("rstResultCore", 64'(result_core), 64'd0);
        checkOutput("rstHalted", 64'(halted), 64'd0);
        checkOutput("rstStuck", 64'(stuck), 64'd0);
        checkOutput("rstStuckCore", 64'(stuck_core), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);

        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("vec%0d.valid", k), 64'(issue_valid), 64'(vecs[k].expValid));
            checkOutput($sformatf("vec%0d.result", k), 64'(result), 64'(vecs[k].expResult));
            checkOutput($sformatf("vec%0d.halted", k), 64'(halted), 64'(vecs[k].expHalted));
            if (vecs[k].expValid) begin
                checkOutput($sformatf("vec%0d.core", k), 64'(issue_core), 64'(vecs[k].expCore));
                checkOutput($sformatf("vec%0d.nstep", k), 64'(issue_nstep), 64'(vecs[k].expNstep));
            end
            if (vecs[k].expResult != 8'd0) begin
                checkOutput($sformatf("vec%0d.resultCore", k), 64'(result_core), 64'd0);
            end
            applyStimulus(vecs[k].step0, vecs[k].step1, vecs[k].ready, vecs[k].rValid, vecs[k].rResult);
            nextCycle();
        end

        // Both cores stepping every cycle: grants alternate and stay small.
        resetDut();
        applyStimulus(8'd1, 8'd1, 1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            serveOne(SIMV_GOODTRAP, gCore, gNstep, gSeen);
            checkOutput($sformatf("alt%0d.seen", k), 64'(gSeen), 64'd1);
            checkOutput($sformatf("alt%0d.core", k), 64'(gCore), 64'(k % 2));
            checkOutput($sformatf("alt%0d.bounded", k), 64'((gNstep >= 8'd1) && (gNstep <= 8'd8)), 64'd1);
        end
        checkOutput("altOverflow", 64'(overflow), 64'd0);

        // Core 1 accumulates 300 while the port is busy: 255 then 45.
        resetDut();
        applyStimulus(8'd0, 8'd1, 1'b0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd150, 1'b0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd150, 1'b0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
        serveOne(SIMV_GOODTRAP, gCore, gNstep, gSeen);
        checkOutput("split0.seen", 64'(gSeen), 64'd1);
        checkOutput("split0.nstep", 64'(gNstep), 64'd1);
        checkOutput("split0.result", 64'(result), 64'(SIMV_GOODTRAP));
        serveOne(SIMV_GOODTRAP, gCore, gNstep, gSeen);
        checkOutput("split1.core", 64'(gCore), 64'd1);
        checkOutput("split1.nstep", 64'(gNstep), 64'd255);
        serveOne(SIMV_GOODTRAP, gCore, gNstep, gSeen);
        checkOutput("split2.core", 64'(gCore), 64'd1);
        checkOutput("split2.nstep", 64'(gNstep), 64'd45);
        sawValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            nextCycle();
            sawValid = sawValid | issue_valid;
        end
        checkOutput("splitDrained", 64'(sawValid), 64'd0);

        // Back-pressure hold, then FAIL halts the scheduler for good.
        resetDut();
        applyStimulus(8'd5, 8'd0, 1'b0, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
        gSeen = 1'b0;
        for (int k = 0; k < 20 && !gSeen; k++) begin
            if (issue_valid) gSeen = 1'b1;
            else nextCycle();
        end
        checkOutput("holdSeen", 64'(gSeen), 64'd1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(8'd0, 8'd7, 1'b0, 1'b0, 8'd0);
            checkOutput($sformatf("hold%0d.valid", k), 64'(issue_valid), 64'd1);
            checkOutput($sformatf("hold%0d.core", k), 64'(issue_core), 64'd0);
            checkOutput($sformatf("hold%0d.nstep", k), 64'(issue_nstep), 64'd5);
            nextCycle();
        end
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b1, SIMV_FAIL);
        nextCycle();
        applyStimulus(8'd2, 8'd2, 1'b1, 1'b0, 8'd0);
        checkOutput("failResult", 64'(result), 64'(SIMV_FAIL));
        checkOutput("failResultCore", 64'(result_core), 64'd0);
        checkOutput("failHalted", 64'(halted), 64'd1);
        sawValid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            nextCycle();
            sawValid = sawValid | issue_valid;
        end
        checkOutput("haltNoIssue", 64'(sawValid), 64'd0);
        checkOutput("haltSticky", 64'(halted), 64'd1);

        // Watchdog with core 1 silent; core 0 keeps the FSM busy.
        resetDut();
        stuck_limit = 64'd100;
        applyStimulus(8'd1, 8'd0, 1'b1, 1'b1, SIMV_GOODTRAP);
        repeat (98) nextCycle();
        checkOutput("stuckEarly", 64'(stuck), 64'd0);
        repeat (4) nextCycle();
        checkOutput("stuckSet", 64'(stuck), 64'd1);
        checkOutput("stuckCore", 64'(stuck_core), 64'd1);
        checkOutput("stuckNoHalt", 64'(halted), 64'd0);

        resetDut();
        stuck_limit = 64'd0;
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
        repeat (150) nextCycle();
        checkOutput("stuckDisabled", 64'(stuck), 64'd0);

        // Accumulator saturation with the port blocked.
        resetDut();
        applyStimulus(8'd0, 8'd255, 1'b0, 1'b0, 8'd0);
        repeat (100) nextCycle();
        checkOutput("ovfEarly", 64'(overflow), 64'd0);
        repeat (200) nextCycle();
        checkOutput("ovfSet", 64'(overflow), 64'd1);
        applyStimulus(8'd0, 8'd0, 1'b0, 1'b0, 8'd0);
        repeat (3) nextCycle();
        checkOutput("ovfSticky", 64'(overflow), 64'd1);

        // Reset while waiting for a response, then a late response.
        resetDut();
        applyStimulus(8'd4, 8'd0, 1'b1, 1'b0, 8'd0);
        nextCycle();
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
        gSeen = 1'b0;
        for (int k = 0; k < 20 && !gSeen; k++) begin
            if (issue_valid) gSeen = 1'b1;
            else nextCycle();
        end
        checkOutput("midSeen", 64'(gSeen), 64'd1);
        checkOutput("midNstep", 64'(issue_nstep), 64'd4);
        nextCycle();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstValid", 64'(issue_valid), 64'd0);
        checkOutput("midRstCore", 64'(issue_core), 64'd0);
        checkOutput("midRstNstep", 64'(issue_nstep), 64'd0);
        checkOutput("midRstResult", 64'(result), 64'd0);
        checkOutput("midRstHalted", 64'(halted), 64'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b1, SIMV_GOODTRAP);
        nextCycle();
        applyStimulus(8'd0, 8'd0, 1'b1, 1'b0, 8'd0);
        checkOutput("lateRespResult", 64'(result), 64'd0);
        sawValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            nextCycle();
            sawValid = sawValid | issue_valid | (result != 8'd0);
        end
        checkOutput("lateRespQuiet", 64'(sawValid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
